seq_multiplier: RTL and testbench

Parametrised multi-cycle shift-add multiplier that computes the full-width product of two WIDTH-bit operands in signed or unsigned mode. It is the sequential successor to the combinational 16×16 multiplier and trades latency (WIDTH cycles) for area. It has valid/ready handshakes on both the operand side and the result side, so it can be placed between pipelined producers and consumers that can stall.

---
 rtl/seq_multiplier.sv | 92 +++++++++
 tb/tb_seq_multiplier.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier, signed or unsigned, with valid/ready
// handshakes on operands and result. One operand pair in flight at a time.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sm);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (sm && sv < 0) return -v;
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic               n);
    return n ? -v : v;
  endfunction

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
            mplier <= magnitude(b, signed_mode);
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= apply_sign(acc_next, neg);
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed corners at WIDTH=16 plus
// randomised traffic with output stalls at WIDTH=8, 16 and 32.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0, sm = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [31:0] product;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8;
  logic [15:0] product8;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32;
  logic [63:0] product32;

  int errors = 0;
  int checks = 0;

  logic [31:0] q16[$];
  logic [15:0] q8[$];
  logic [63:0] q32[$];

  seq_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(sm), .out_valid(out_valid),
    .out_ready(out_ready), .product(product));

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8));

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .signed_mode(sm32), .out_valid(out_valid32),
    .out_ready(out_ready32), .product(product32));

  // Reference: widen to 64-bit signed integers and multiply directly.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int w);
    logic signed [63:0] sx, sy, one;
    one = 64'sd1;
    sx = {32'h0, x};
    sy = {32'h0, y};
    if (s && x[w-1]) sx = sx - (one <<< w);
    if (s && y[w-1]) sy = sy - (one <<< w);
    return sx * sy;
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    logic [63:0] r;
    r = ref_mul({16'h0, x}, {16'h0, y}, s, 16);
    return r[31:0];
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send16(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xs, input logic [31:0] expv);
    int n = 0;
    a = xa; b = xb; sm = xs; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send16_accept in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    q16.push_back(expv);
  endtask

  task automatic recv16(output logic [31:0] p, output int lat, input int stall);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    lat = n;
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL recv16_timeout out_valid=%0b required 1", out_valid);
    end
    repeat (stall) begin @(posedge clk); #1; end
    p = product;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
    checks++; if (in_ready8 !== 1'b1 || in_ready32 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_w8_w32 got=%0b%0b exp=11", in_ready8, in_ready32);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_directed(input string name, input logic [15:0] xa, input logic [15:0] xb,
                              input logic xs, input logic [31:0] expv);
    logic [31:0] p, e;
    int lat;
    send16(xa, xb, xs, expv);
    recv16(p, lat, 0);
    e = q16.pop_front();
    checks++;
    if (p !== e) begin errors++; $display("FAIL %s product got=%h exp=%h", name, p, e); end
    checks++;
    if (lat != 16) begin errors++; $display("FAIL %s latency got=%0d exp=16", name, lat); end
  endtask

  task automatic test_unsigned;
    run_directed("unsigned_1234x5678", 16'h1234, 16'h5678, 1'b0, 32'h06260060);
  endtask

  task automatic test_modes;
    run_directed("signed_ffffx2", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
    run_directed("unsigned_ffffx2", 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);
  endtask

  task automatic test_signed_corners;
    run_directed("signed_8000x7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    run_directed("signed_8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    run_directed("zero_x_ffff", 16'h0000, 16'hFFFF, 1'b1, 32'h00000000);
  endtask

  task automatic test_backpressure;
    logic [31:0] p, e;
    int n = 0, lat;
    send16(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF);
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; sm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (product !== q16[0] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d product=%h in_ready=%0b out_valid=%0b exp %h/0/1",
                 i, product, in_ready, out_valid, q16[0]);
      end
    end
    in_valid = 1'b0;
    p = product;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    e = q16.pop_front();
    checks++;
    if (p !== e) begin errors++; $display("FAIL backpressure_result got=%h exp=%h", p, e); end
    checks++;
    if (product !== e || in_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_after product=%h in_ready=%0b exp %h/1", product, in_ready, e);
    end
    run_directed("after_backpressure", 16'h0007, 16'h0006, 1'b0, 32'd42);
    lat = 0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] p, e;
    int n = 0;
    out_ready = 1'b1;
    send16(16'd100, 16'd200, 1'b0, 32'd20000);
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    p = product;
    checks++;
    if (n != 16) begin errors++; $display("FAIL b2b_latency got=%0d exp=16", n); end
    a = 16'hFFFD; b = 16'h0005; sm = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_one_cycle out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    e = q16.pop_front();
    checks++;
    if (p !== e) begin errors++; $display("FAIL b2b_first got=%h exp=%h", p, e); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    q16.push_back(32'hFFFFFFF1);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    p = product;
    @(posedge clk); #1;
    out_ready = 1'b0;
    e = q16.pop_front();
    checks++;
    if (p !== e || n != 16) begin
      errors++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=16", p, n, e);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] discard;
    int seen = 0;
    send16(16'h1234, 16'h00FF, 1'b0, 32'h0);
    discard = q16.pop_back();
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid in_ready=%0b out_valid=%0b product=%h exp 1/0/0 (dropped %h)",
               in_ready, out_valid, product, discard);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_no_output got=%0d exp=0", seen); end
    run_directed("after_reset_3x5", 16'd3, 16'd5, 1'b0, 32'd15);
  endtask

  task automatic test_random16;
    logic [15:0] xa, xb;
    logic xs;
    logic [31:0] p, e;
    int lat;
    for (int i = 0; i < 200; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) xa = 16'h8000;
      if ($urandom_range(0, 7) == 0) xb = 16'($urandom_range(0, 1)) ? 16'hFFFF : 16'h0000;
      send16(xa, xb, xs, ref16(xa, xb, xs));
      recv16(p, lat, $urandom_range(0, 3));
      e = q16.pop_front();
      checks++;
      if (p !== e || lat != 16) begin
        errors++;
        $display("FAIL rand16 #%0d a=%h b=%h s=%0b got=%h lat=%0d exp=%h lat=16", i, xa, xb, xs, p, lat, e);
      end
    end
  endtask

  task automatic test_random8;
    logic [63:0] r;
    logic [15:0] p, e;
    int n;
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
      in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      r = ref_mul({24'h0, a8}, {24'h0, b8}, sm8, 8);
      q8.push_back(r[15:0]);
      n = 0;
      while (!out_valid8 && n < 100) begin @(posedge clk); #1; n++; end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      p = product8;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      e = q8.pop_front();
      checks++;
      if (p !== e || n != 8) begin
        errors++;
        $display("FAIL rand8 #%0d a=%h b=%h s=%0b got=%h lat=%0d exp=%h lat=8", i, a8, b8, sm8, p, n, e);
      end
    end
  endtask

  task automatic test_random32;
    logic [63:0] p, e;
    int n;
    for (int i = 0; i < 200; i++) begin
      a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a32 = 32'h80000000;
      in_valid32 = 1'b1;
      n = 0;
      while (!in_ready32 && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      q32.push_back(ref_mul(a32, b32, sm32, 32));
      n = 0;
      while (!out_valid32 && n < 100) begin @(posedge clk); #1; n++; end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      p = product32;
      out_ready32 = 1'b1;
      @(posedge clk); #1;
      out_ready32 = 1'b0;
      e = q32.pop_front();
      checks++;
      if (p !== e || n != 32) begin
        errors++;
        $display("FAIL rand32 #%0d a=%h b=%h s=%0b got=%h lat=%0d exp=%h lat=32", i, a32, b32, sm32, p, n, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_modes;
    test_signed_corners;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random16;
    test_random8;
    test_random32;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
